tlul_host_arbiter: RTL
======================

// Module: tlul_host_arbiter
// PURPOSE
// Shares one TL-UL-to-AXI4 bridge between NumHosts TL-UL hosts. Arbitrates A requests round-robin and registers the winner.
// Forwards it downstream and captures the single D response, which the bridge does not hold. Returns it to the owning host.
// Sits directly upstream of tlul_to_axi4. At most one transaction is outstanding. Unsupported opcodes are answered locally.
// PARAMETERS
// NumHosts     4    number of TL-UL hosts, >=2, need not be a power of two
// DataWidth    64   TL data width
// AddrWidth    32   TL address width
// SourceWidth  8    TL source id width
// MaxSize      6    TL size field width
// PORTS
// clk_i          in   1                   clock
// rst_i          in   1                   synchronous, active-high reset
// h_a_valid      in   NumHosts            per-host A valid
// h_a_ready      out  NumHosts            per-host A ready (one-hot or zero)
// h_a_address    in   NumHosts*AddrWidth  per-host A fields, packed, host i at slice i
// h_a_data       in   NumHosts*DataWidth  also packed per host
// h_a_mask       in   NumHosts*DataWidth/8, packed per host
// h_a_source     in   NumHosts*SourceWidth, packed per host
// h_a_size       in   NumHosts*MaxSize, packed per host
// h_a_opcode     in   NumHosts*3, packed per host
// h_d_valid      out  NumHosts            per-host D valid (one-hot or zero)
// h_d_ready      in   NumHosts            per-host D ready
// h_d_data/source/opcode/error  out  DataWidth/SourceWidth/3/2  shared D payload, meaningful only where h_d_valid set
// m_a_valid      out  1                   to bridge tl_a_valid
// m_a_ready      in   1                   from bridge tl_a_ready
// m_a_address/data/mask/source/size/opcode  out  as host fields  registered request to bridge
// m_d_valid      in   1                   from bridge tl_d_valid
// m_d_ready      out  1                   to bridge tl_d_ready
// m_d_data/source/opcode/error  in   as h_d_*  bridge D payload
// busy_o         out  1                   state != IDLE
// spurious_rsp_o out  1                   sticky: m_d_valid seen outside WAIT_RSP
// BEHAVIOUR
// - Reset (rst_i high at posedge) sets state=IDLE, rr_ptr=0, owner=0, and all capture registers to 0.
//   Reset clears spurious_rsp_o. Every output is 0 while in reset. Any in-flight transaction is dropped.
// - The bridge must share the same reset.
// - FSM IDLE -> {REQ | RSP} -> WAIT_RSP -> RSP -> IDLE:
//   IDLE: the winner is the first i with h_a_valid[i], scanning from rr_ptr upward with wrap NumHosts-1 -> 0.
//     h_a_ready[winner] = 1 combinationally, so the host is accepted this cycle.
//     On acceptance, capture the winner's A fields, owner <= winner, rr_ptr <= (winner==NumHosts-1) ? 0 : winner+1.
//     Opcode 3'b000 (Get) or 3'b001 (PutFullData) -> REQ.
//     Any other opcode -> RSP with locally generated response: opcode 3'b000, error 2'b10, data 0, source = captured source.
//   REQ: m_a_valid=1, fields from registers, stable until m_a_ready. m_a_valid && m_a_ready -> WAIT_RSP.
//   WAIT_RSP: m_d_ready=1. On m_d_valid, capture m_d_data/source/opcode/error -> RSP.
//     The bridge pulses D without waiting, so the capture must be unconditional.
//   RSP: h_d_valid[owner]=1 with the registered payload, held stable. h_d_ready[owner] -> IDLE.
// - h_a_ready is 0 outside IDLE. m_d_ready is 0 outside WAIT_RSP.
//   m_d_valid outside WAIT_RSP is ignored and sets spurious_rsp_o.
// - Latency: a host accepted at cycle 0 sees m_a_valid at cycle 1.
//   A D response captured at cycle n gives h_d_valid at cycle n+1. Local error response: h_d_valid at cycle 1.
// - Minimum turnaround RSP->IDLE is 1 cycle; a new grant cannot occur in the RSP cycle.
// - Simultaneous requests only compete in IDLE. Non-winners keep their valid asserted and remain pending.
// TESTING
// 1. Host1 Get addr 0x1000, src 0x12; bridge m_d_valid data 0xDEAD, err 0 -> h_d_valid=4'b0010, data 0xDEAD, src 0x12.
// 2. All 4 hosts hold valid and respond immediately -> 8 grants in order 0,1,2,3,0,1,2,3; only one outstanding at a time.
// 3. Host2 opcode 3'b100 -> m_a_valid never set; h_d_valid[2]=1 at cycle 1 with error 2'b10, opcode 0.
// 4. Hold h_d_ready[0]=0 for 5 cycles in RSP -> payload stable, h_a_ready all 0, no new grant until release.
// 5. rst_i in WAIT_RSP, then m_d_valid after release -> outputs 0, rr_ptr 0, response ignored, spurious_rsp_o=1.
// 6. NumHosts=3, host2 then host0 request -> rr_ptr wraps 2->0 and host0 is granted.

Source files
------------

// File: rtl/tlul_host_arbiter.sv
// Round-robin TL-UL host arbiter in front of a single tlul_to_axi4 bridge.
// One transaction in flight; unsupported opcodes get a local error response.
module tlul_host_arbiter #(
    parameter int NumHosts    = 4,
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 32,
    parameter int SourceWidth = 8,
    parameter int MaxSize     = 6,
    localparam int MaskWidth  = DataWidth / 8,
    localparam int IdxW       = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumHosts-1:0]             h_a_valid,
    output logic [NumHosts-1:0]             h_a_ready,
    input  logic [NumHosts*AddrWidth-1:0]   h_a_address,
    input  logic [NumHosts*DataWidth-1:0]   h_a_data,
    input  logic [NumHosts*MaskWidth-1:0]   h_a_mask,
    input  logic [NumHosts*SourceWidth-1:0] h_a_source,
    input  logic [NumHosts*MaxSize-1:0]     h_a_size,
    input  logic [NumHosts*3-1:0]           h_a_opcode,
    output logic [NumHosts-1:0]             h_d_valid,
    input  logic [NumHosts-1:0]             h_d_ready,
    output logic [DataWidth-1:0]            h_d_data,
    output logic [SourceWidth-1:0]          h_d_source,
    output logic [2:0]                      h_d_opcode,
    output logic [1:0]                      h_d_error,
    output logic                            m_a_valid,
    input  logic                            m_a_ready,
    output logic [AddrWidth-1:0]            m_a_address,
    output logic [DataWidth-1:0]            m_a_data,
    output logic [MaskWidth-1:0]            m_a_mask,
    output logic [SourceWidth-1:0]          m_a_source,
    output logic [MaxSize-1:0]              m_a_size,
    output logic [2:0]                      m_a_opcode,
    input  logic                            m_d_valid,
    output logic                            m_d_ready,
    input  logic [DataWidth-1:0]            m_d_data,
    input  logic [SourceWidth-1:0]          m_d_source,
    input  logic [2:0]                      m_d_opcode,
    input  logic [1:0]                      m_d_error,
    output logic                            busy_o,
    output logic                            spurious_rsp_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        RSP
    } state_e;

    state_e state_q, state_d;

    logic [IdxW-1:0]        rr_ptr_q, owner_q, winner;
    logic [IdxW:0]          idx;
    logic                   any_req, accept, capture, supported;
    logic [2:0]             win_opcode;
    logic [AddrWidth-1:0]   a_addr_q;
    logic [DataWidth-1:0]   a_data_q;
    logic [MaskWidth-1:0]   a_mask_q;
    logic [SourceWidth-1:0] a_source_q;
    logic [MaxSize-1:0]     a_size_q;
    logic [2:0]             a_opcode_q;
    logic [DataWidth-1:0]   d_data_q;
    logic [SourceWidth-1:0] d_source_q;
    logic [2:0]             d_opcode_q;
    logic [1:0]             d_error_q;
    logic                   spur_q;

    // First requester at or after rr_ptr, wrapping at NumHosts.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < NumHosts; k++) begin
            idx = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
            if (idx >= (IdxW+1)'(NumHosts)) begin
                idx = idx - (IdxW+1)'(NumHosts);
            end
            if (!any_req && h_a_valid[idx[IdxW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[IdxW-1:0];
            end
        end
    end

    assign win_opcode = h_a_opcode[int'(winner)*3 +: 3];
    assign supported  = (win_opcode == 3'b000) || (win_opcode == 3'b001);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        h_a_ready = '0;
        h_d_valid = '0;
        m_a_valid = 1'b0;
        m_d_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    accept            = 1'b1;
                    h_a_ready[winner] = 1'b1;
                    state_d           = supported ? REQ : RSP;
                end
            end
            REQ: begin
                m_a_valid = 1'b1;
                if (m_a_ready) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                m_d_ready = 1'b1;
                if (m_d_valid) begin
                    capture = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                h_d_valid[owner_q] = 1'b1;
                if (h_d_ready[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs stay quiet throughout reset, even before the edge lands.
        if (rst_i) begin
            accept    = 1'b0;
            capture   = 1'b0;
            h_a_ready = '0;
            h_d_valid = '0;
            m_a_valid = 1'b0;
            m_d_ready = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            a_addr_q   <= '0;
            a_data_q   <= '0;
            a_mask_q   <= '0;
            a_source_q <= '0;
            a_size_q   <= '0;
            a_opcode_q <= '0;
            d_data_q   <= '0;
            d_source_q <= '0;
            d_opcode_q <= '0;
            d_error_q  <= '0;
            spur_q     <= 1'b0;
        end else begin
            if (accept) begin
                a_addr_q   <= h_a_address[int'(winner)*AddrWidth +: AddrWidth];
                a_data_q   <= h_a_data[int'(winner)*DataWidth +: DataWidth];
                a_mask_q   <= h_a_mask[int'(winner)*MaskWidth +: MaskWidth];
                a_source_q <= h_a_source[int'(winner)*SourceWidth +: SourceWidth];
                a_size_q   <= h_a_size[int'(winner)*MaxSize +: MaxSize];
                a_opcode_q <= win_opcode;
                owner_q    <= winner;
                rr_ptr_q   <= (winner == IdxW'(NumHosts-1)) ? '0 : winner + 1'b1;
                if (!supported) begin
                    d_data_q   <= '0;
                    d_source_q <= h_a_source[int'(winner)*SourceWidth +: SourceWidth];
                    d_opcode_q <= 3'b000;
                    d_error_q  <= 2'b10;
                end
            end
            // The bridge does not hold D, so take it the cycle it appears.
            if (capture) begin
                d_data_q   <= m_d_data;
                d_source_q <= m_d_source;
                d_opcode_q <= m_d_opcode;
                d_error_q  <= m_d_error;
            end
            if (m_d_valid && (state_q != WAIT_RSP)) begin
                spur_q <= 1'b1;
            end
        end
    end

    assign m_a_address    = rst_i ? '0 : a_addr_q;
    assign m_a_data       = rst_i ? '0 : a_data_q;
    assign m_a_mask       = rst_i ? '0 : a_mask_q;
    assign m_a_source     = rst_i ? '0 : a_source_q;
    assign m_a_size       = rst_i ? '0 : a_size_q;
    assign m_a_opcode     = rst_i ? '0 : a_opcode_q;
    assign h_d_data       = rst_i ? '0 : d_data_q;
    assign h_d_source     = rst_i ? '0 : d_source_q;
    assign h_d_opcode     = rst_i ? '0 : d_opcode_q;
    assign h_d_error      = rst_i ? '0 : d_error_q;
    assign busy_o         = !rst_i && (state_q != IDLE);
    assign spurious_rsp_o = !rst_i && spur_q;

endmodule
